// File: rtl/stopwatch_lap_if.sv
// stopwatch_lap_if: control inputs and display outputs of the stopwatch
//   start_stop, clear, lap : controller -> stopwatch (levels, synchronous to clk_base)
//   digits                 : BCD display value, digit 0 in bits [3:0]
//   running, lap_active, overflow : registered status flags
interface stopwatch_lap_if #(parameter int DIGITS = 4);
  logic start_stop;
  logic clear;
  logic lap;
  logic [4*DIGITS-1:0] digits;
  logic running;
  logic lap_active;
  logic overflow;
  modport master(output start_stop, clear, lap, input digits, running, lap_active, overflow);
  modport slave(input start_stop, clear, lap, output digits, running, lap_active, overflow);
endinterface

// File: rtl/stopwatch_lap.sv
// stopwatch_lap: parametrised BCD stopwatch with start/stop toggle, lap hold and wrap/saturate overflow
//   clk_base : system clock
//   reset    : asynchronous active-high reset
//   sw       : stopwatch_lap_if.slave (start_stop, clear, lap in; digits, running, lap_active, overflow out)
module stopwatch_lap #(
  parameter int DIGITS = 4,
  parameter int TICK_DIV = 1000000,
  parameter bit SAT_MODE = 1'b0
) (
  input logic clk_base,
  input logic reset,
  stopwatch_lap_if.slave sw
);
  localparam int W = 4 * DIGITS;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] count, lap_reg, count_inc;
  logic [PW-1:0] prescale;
  logic ss_q, lap_q, se, le, tick, all9, carry;
  logic running, lap_active, overflow;
  assign se = sw.start_stop & ~ss_q;
  assign le = sw.lap & ~lap_q;
  assign tick = running && prescale == PW'(TICK_DIV - 1);
  // Ripple BCD increment; the final carry means every digit was 9.
  always_comb begin
    carry = 1'b1;
    count_inc = count;
    for (int i = 0; i < DIGITS; i++) begin
      count_inc[4*i+:4] = carry ? (count[4*i+:4] == 4'd9 ? 4'd0 : count[4*i+:4] + 4'd1) : count[4*i+:4];
      carry = carry & (count[4*i+:4] == 4'd9);
    end
    all9 = carry;
  end
  always_ff @(posedge clk_base or posedge reset) begin
    if (reset) begin
      ss_q <= 1'b0;
      lap_q <= 1'b0;
      count <= '0;
      lap_reg <= '0;
      prescale <= '0;
      running <= 1'b0;
      lap_active <= 1'b0;
      overflow <= 1'b0;
    end else begin
      ss_q <= sw.start_stop;
      lap_q <= sw.lap;
      if (sw.clear) begin
        count <= '0;
        prescale <= '0;
        overflow <= 1'b0;
        lap_active <= 1'b0;
      end else begin
        if (running) prescale <= tick ? '0 : prescale + 1'b1;
        if (tick) begin
          count <= (SAT_MODE && all9) ? count : count_inc;
          if (all9) overflow <= 1'b1;
        end
        if (le) begin
          lap_active <= ~lap_active;
          if (!lap_active) lap_reg <= count;
        end
      end
      // Saturation stop wins over a simultaneous toggle; a saturated watch ignores toggles until clear.
      if (SAT_MODE && !sw.clear && tick && all9) running <= 1'b0;
      else if (se && !(SAT_MODE && overflow)) running <= ~running;
    end
  end
  assign sw.digits = lap_active ? lap_reg : count;
  assign sw.running = running;
  assign sw.lap_active = lap_active;
  assign sw.overflow = overflow;
endmodule

// File: doc/stopwatch_lap.md
Name: stopwatch_lap

Overview:
Parametrised BCD stopwatch, the next generation of the fixed 4-digit full_counter. It adds:
- configurable digit count and prescale;
- an edge-detected start/stop toggle;
- synchronous clear;
- a lap-hold display;
- selectable wrap or saturate overflow with a sticky flag.

It sits between the board clock and the seven-segment display driver, which consumes the digits bus.

Parameters:
DIGITS, 4, number of BCD digits; range 1..8.
TICK_DIV, 1000000, clk_base cycles per count increment; range 1..2^26.
SAT_MODE, 0, overflow handling: 0 = wrap to zero, 1 = saturate at all-9s and stop.

Ports:
clk_base  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
start_stop  in  1  level input; each rising edge (sampled on clk_base) toggles running.
clear  in  1  synchronous clear, active-high.
lap  in  1  level input; each rising edge toggles lap hold.
digits  out  4*DIGITS  BCD display value; digit 0 (least significant) in bits [3:0].
running  out  1  1 while counting.
lap_active  out  1  1 while the display is frozen.
overflow  out  1  sticky; set when the count passes all-9s.

Behaviour:
- Reset (asynchronous, active-high):
  - count, lap_reg, prescale, running, lap_active, overflow = 0; digits = 0.
  - start_stop and lap edge-detect registers = 0. A level already high when reset releases therefore produces an edge on the first clock.
- Edge detect:
  - se = start_stop & ~ss_q; le = lap & ~lap_q; ss_q and lap_q are registered each cycle.
  - Inputs are synchronous to clk_base; debouncing is upstream.
- Prescaler, only while running == 1:
  - If prescale == TICK_DIV-1: prescale <= 0 and tick = 1 (combinational, same cycle).
  - Otherwise prescale <= prescale + 1.
  - While stopped, prescale holds. Restart resumes mid-period with no loss.
  - TICK_DIV = 1 gives a tick every running cycle.
- Count (DIGITS-digit BCD, digit i ∈ 0..9):
  - On tick, digit 0 increments. Carry into digit i+1 occurs when digits 0..i are all 9.
  - A count update becomes visible on digits (if not holding) the cycle after the tick edge.
- Overflow, on tick with count = all-9s:
  - SAT_MODE = 0: count <= 0, overflow <= 1, running unchanged.
  - SAT_MODE = 1: count holds all-9s, running <= 0, overflow <= 1.
  - overflow is cleared only by reset or clear.
- Run toggle:
  - se: running <= ~running.
  - In SAT_MODE = 1 with overflow = 1, se is ignored and running stays 0 until clear.
- Lap:
  - le with lap_active = 0: lap_reg <= count (pre-edge value) and lap_active <= 1.
  - le with lap_active = 1: lap_active <= 0.
  - digits = lap_active ? lap_reg : count. The count keeps advancing underneath the hold.
- Clear:
  - count, prescale, overflow <= 0; lap_active <= 0.
  - running is unchanged; a running watch restarts from 0.
- Simultaneous events, same edge:
  - clear beats tick, overflow and le.
  - tick is evaluated with the pre-edge running value, so se plus tick gives both the increment and the toggle.
  - le plus tick: lap_reg captures the pre-increment count.
  - se plus overflow in SAT_MODE = 1: running ends at 0.
- Reset mid-count asserts immediately (asynchronously) and returns all state to the reset values above.
- No combinational path from inputs to digits except through registers. running, lap_active and overflow are registered.

Test Plan:
1. DIGITS=4, TICK_DIV=4: reset, one start_stop pulse, 40 cycles → digits = 0x0010; running = 1; tick every 4th cycle.
2. Mid-period stop: TICK_DIV=4, start, 6 cycles, stop, 20 cycles idle, start, 2 cycles → digits = 0x0002 (prescale resumed from 2), held constant while stopped.
3. Lap: at count 0x0007 pulse lap, run 12 more ticks → digits stay 0x0007 and lap_active = 1. Second lap pulse → digits = 0x0019.
4. Wrap: DIGITS=2, TICK_DIV=1, SAT_MODE=0, run 100 cycles → 99 → 00 with overflow = 1 and running = 1. clear → overflow = 0, digits = 00.
5. Saturate: DIGITS=2, TICK_DIV=1, SAT_MODE=1, run 120 cycles → digits = 0x99, running = 0, overflow = 1. A start_stop pulse is ignored. clear then start resumes from 00.
6. Collisions and async reset:
   - clear on the same edge as a tick → digits = 0.
   - le on a tick edge → lap value is the pre-increment count.
   - reset asserted between clock edges → all outputs 0 before the next edge.
